arc_mem_ctrl: RTL and testbench
===============================

Name: arc_mem_ctrl

Overview:
- Main-memory access controller for the ARC datapath; sits directly downstream of the microinstruction RD/WR bits and upstream of the datapath's data_MM input.
- Per microinstruction, it latches address (bus A) and write data (bus B), runs a req/ack transaction with word-addressed main memory, and returns read data on data_MM.
- While the access is in flight it asserts stall so the microsequencer holds the current microinstruction.
- It detects misaligned, out-of-range and timed-out accesses.

Parameters:
- ADDR_W, 16, implemented byte-address bits; mem_addr carries bits ADDR_W-1:2.
- TIMEOUT, 255, maximum cycles in BUSY without mem_ack before abort (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd  in  1  mir RD bit: read memory into bus C this microinstruction.
- wr  in  1  mir WR bit: write bus B to memory.
- addr_in  in  32  byte address from bus A.
- wdata_in  in  32  write data from bus B.
- data_MM  out  32  read data to the datapath bus C mux.
- stall  out  1  hold microsequencer/mir.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read; valid with mem_req.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it.
- mem_rdata  in  32  read data.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 misaligned, 10 out-of-range, 11 timeout/illegal.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req, mem_we, stall, err all 0; err_code=00; data_MM, mem_addr, mem_wdata, timeout counter all 0.
- States are IDLE, BUSY and DONE.
- IDLE, access request (rd|wr) with no fault:
  - Latch addr_in[ADDR_W-1:2], wdata_in and we=wr.
  - Next state BUSY; mem_req<=1; counter<=0.
  - stall=1 combinationally this cycle.
- IDLE, faults (no transaction; stall=0; data_MM unchanged; next state DONE):
  - rd&wr both set: err_code 11.
  - addr_in[1:0]≠0: err_code 01.
  - Any addr_in bit ≥ ADDR_W set: err_code 10.
  - Priority when several faults apply: illegal > misaligned > range.
- BUSY:
  - stall=1; mem_req=1; mem_addr, mem_we and mem_wdata stable at the latched values.
  - On mem_ack: if read, data_MM<=mem_rdata. Then mem_req<=0, next state DONE.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 without ack: mem_req<=0, err<=1, err_code<=11, next state DONE, data_MM unchanged.
- DONE:
  - stall=0 for exactly one cycle so the microsequencer advances.
  - rd/wr are still asserted from the same microinstruction and are ignored.
  - Next state IDLE.
- data_MM is registered and holds its value until the next successful read ack. A destination register rewritten repeatedly during stall therefore receives a stable value, and a final write in DONE gets the valid data.
- Address and data are latched, so a read whose destination is also its address register (r1←M[r1]) is safe.
- Latency: minimum access is 3 cycles (request cycle, BUSY with immediate ack, DONE), with stall high for 2.
- Back-to-back accesses: DONE→IDLE→new access; one idle cycle minimum between requests.
- err is sticky. err_code records the first error only, and both clear only on reset.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-BUSY aborts the access immediately; mem_req drops asynchronously.

Decomposition:
- Package arc_mem_pkg:
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Err code constants: ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_TMO.
  - MIR bit positions: RD=19, WR=18.
- Sub-module mem_timeout_counter:
  - Inputs clk, rst, clear, enable.
  - Output expired, asserted when count == TIMEOUT-1.
  - Width $clog2(TIMEOUT+1).

Test Plan:
- Read, ack 2 cycles after mem_req: rd=1, addr_in=0x0000_0010, mem_rdata=0xDEADBEEF → mem_addr=0x004, mem_we=0; stall high 3 cycles; data_MM=0xDEADBEEF in DONE; then IDLE.
- Write, immediate ack: wr=1, addr_in=0x20, wdata_in=0x12345678 → mem_we=1, mem_wdata=0x12345678; addr_in changes during BUSY while mem_addr stays 0x008; stall high 2 cycles.
- Misaligned read: rd=1, addr_in=0x0000_0013 → mem_req never asserts; stall=0; err=1; err_code=01; data_MM unchanged.
- Timeout with TIMEOUT=4 and no ack → mem_req high 4 cycles then drops; err_code=11; DONE then IDLE. A later ack pulse is ignored.
- Out-of-range and illegal: addr_in=0x0001_0000 (ADDR_W=16) → err_code=10. After reset, rd=wr=1 → err_code=11; no transaction in either case.
- Reset mid-BUSY: rst=0 while mem_req=1 → mem_req, stall and data_MM go to 0 without waiting for clk. After release, a normal read completes correctly.

Source files
------------

// File: rtl/arc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc_mem_pkg
// Brief    : Shared types and constants for the ARC main-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package arc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  // Positions of the RD/WR bits inside the microinstruction register.
  localparam int RD = 19;
  localparam int WR = 18;

endpackage
`default_nettype wire

// File: rtl/arc_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : arc_mem_ctrl_if
// Brief    : Word-addressed main-memory req/ack bus.
// Revision : 1.0 - initial release
// ============================================================================
interface arc_mem_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_counter
// Brief    : Counts cycles spent waiting for mem_ack; flags TIMEOUT-1 reached.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_cnt_w'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/arc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arc_mem_ctrl
// Brief    : ARC main-memory access controller: latches the microinstruction
//            access, runs req/ack with memory and stalls the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module arc_mem_ctrl
  import arc_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] data_MM,
  output logic        stall,
  output logic        err,
  output logic [1:0]  err_code,
  arc_mem_ctrl_if.master mem
);

  state_t            r_state, w_state_nxt;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_mem_wdata, r_data_mm;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic       w_oor, w_expired;
  logic [1:0] w_fault_code;
  logic       w_start, w_fault, w_ack, w_tmo, w_stall;

  generate
    if (ADDR_W < 32) begin : g_range
      assign w_oor = |addr_in[31:ADDR_W];
    end else begin : g_full
      assign w_oor = 1'b0;
    end
  endgenerate

  // Illegal (rd&wr) outranks misaligned, which outranks out-of-range.
  assign w_fault_code = (rd && wr)            ? ERR_TMO   :
                        (addr_in[1:0] != 2'b0) ? ERR_ALIGN :
                        w_oor                  ? ERR_RANGE : ERR_NONE;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_start),
    .enable  (r_state == BUSY),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fault     = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd || wr) begin
          if (w_fault_code != ERR_NONE) begin
            w_fault     = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_start     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem.mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = DONE;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_data_mm   <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= wr;
        r_mem_addr  <= addr_in[ADDR_W-1:2];
        r_mem_wdata <= wdata_in;
      end
      if (w_ack) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) r_data_mm <= mem.mem_rdata;
      end
      if (w_tmo) r_mem_req <= 1'b0;
      // err_code keeps the first error; later faults only re-assert err.
      if (w_fault || w_tmo) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_fault ? w_fault_code : ERR_TMO;
      end
    end
  end

  assign stall         = rst && w_stall;
  assign data_MM       = r_data_mm;
  assign err           = r_err;
  assign err_code      = r_err_code;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_arc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc_mem_ctrl
// Brief    : Directed self-checking bench for arc_mem_ctrl (ADDR_W=16, TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arc_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr_in, wdata_in;
  logic [31:0] data_MM;
  logic        stall, err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  arc_mem_ctrl_if #(.ADDR_W(16)) bus ();

  arc_mem_ctrl #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .data_MM  (data_MM),
    .stall    (stall),
    .err      (err),
    .err_code (err_code),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    rd = 1'b0; wr = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    addr_in = '0; wdata_in = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    apply_reset();
    #1;
    check_val("rst_data_MM",  data_MM,       32'h0);
    check_val("rst_stall",    stall,         32'h0);
    check_val("rst_mem_req",  bus.mem_req,   32'h0);
    check_val("rst_mem_we",   bus.mem_we,    32'h0);
    check_val("rst_mem_addr", bus.mem_addr,  32'h0);
    check_val("rst_wdata",    bus.mem_wdata, 32'h0);
    check_val("rst_err",      {err, err_code}, 32'h0);

    // Read, ack in the second BUSY cycle.
    @(negedge clk); rd = 1'b1; addr_in = 32'h0000_0010; #1;
    check_val("rd_stall_req_cycle", stall, 32'h1);
    check_val("rd_no_req_yet", bus.mem_req, 32'h0);
    @(negedge clk); #1;
    check_val("rd_mem_req", bus.mem_req, 32'h1);
    check_val("rd_mem_addr", bus.mem_addr, 32'h004);
    check_val("rd_mem_we", bus.mem_we, 32'h0);
    check_val("rd_stall_busy1", stall, 32'h1);
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; #1;
    check_val("rd_stall_busy2", stall, 32'h1);
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; #1;
    check_val("rd_done_stall", stall, 32'h0);
    check_val("rd_done_data", data_MM, 32'hDEAD_BEEF);
    check_val("rd_done_req", bus.mem_req, 32'h0);
    @(negedge clk); rd = 1'b0; #1;
    check_val("rd_idle_stall", stall, 32'h0);

    // Write, immediate ack, address bus changes during BUSY.
    @(negedge clk); wr = 1'b1; addr_in = 32'h20; wdata_in = 32'h1234_5678; #1;
    check_val("wr_stall_req_cycle", stall, 32'h1);
    @(negedge clk); addr_in = 32'hFFF0; wdata_in = 32'h0; bus.mem_ack = 1'b1; #1;
    check_val("wr_mem_addr", bus.mem_addr, 32'h008);
    check_val("wr_mem_we", bus.mem_we, 32'h1);
    check_val("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    check_val("wr_mem_req", bus.mem_req, 32'h1);
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check_val("wr_done_stall", stall, 32'h0);
    check_val("wr_done_req", bus.mem_req, 32'h0);
    check_val("wr_data_kept", data_MM, 32'hDEAD_BEEF);
    @(negedge clk); wr = 1'b0; #1;
    check_val("wr_idle_stall", stall, 32'h0);

    // Misaligned read: no transaction.
    @(negedge clk); rd = 1'b1; addr_in = 32'h0000_0013; #1;
    check_val("mis_stall", stall, 32'h0);
    @(negedge clk); #1;
    check_val("mis_req", bus.mem_req, 32'h0);
    check_val("mis_err", {err, err_code}, 32'h5);
    check_val("mis_data", data_MM, 32'hDEAD_BEEF);
    @(negedge clk); rd = 1'b0;

    // Timeout: mem_req high exactly 4 cycles.
    apply_reset();
    @(negedge clk); rd = 1'b1; addr_in = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check_val($sformatf("tmo_req_c%0d", i), {stall, bus.mem_req}, 32'h3);
    end
    @(negedge clk); #1;
    check_val("tmo_req_drop", bus.mem_req, 32'h0);
    check_val("tmo_stall_done", stall, 32'h0);
    check_val("tmo_err", {err, err_code}, 32'h7);
    @(negedge clk); rd = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check_val("tmo_stray_ack_data", data_MM, 32'h0);
    check_val("tmo_stray_ack_req", {stall, bus.mem_req}, 32'h0);

    // Out-of-range, then a misaligned fault must not overwrite err_code.
    apply_reset();
    @(negedge clk); rd = 1'b1; addr_in = 32'h0001_0000; #1;
    check_val("oor_stall", stall, 32'h0);
    @(negedge clk); #1;
    check_val("oor_err", {err, err_code}, 32'h6);
    check_val("oor_req", bus.mem_req, 32'h0);
    @(negedge clk); addr_in = 32'h13;
    @(negedge clk); #1;
    check_val("sticky_code", {err, err_code}, 32'h6);
    @(negedge clk); rd = 1'b0;

    // Illegal rd&wr.
    apply_reset();
    @(negedge clk); rd = 1'b1; wr = 1'b1; addr_in = 32'h10; #1;
    check_val("ill_stall", stall, 32'h0);
    @(negedge clk); #1;
    check_val("ill_err", {err, err_code}, 32'h7);
    check_val("ill_req", bus.mem_req, 32'h0);
    @(negedge clk); rd = 1'b0; wr = 1'b0;

    // Misaligned beats out-of-range.
    apply_reset();
    @(negedge clk); rd = 1'b1; addr_in = 32'h0001_0001;
    @(negedge clk); #1;
    check_val("prio_align", {err, err_code}, 32'h5);
    @(negedge clk); rd = 1'b0;

    // Reset mid-BUSY after a successful read.
    apply_reset();
    @(negedge clk); rd = 1'b1; addr_in = 32'h4;
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check_val("pre_rst_data", data_MM, 32'hCAFE_F00D);
    @(negedge clk); rd = 1'b0;
    @(negedge clk); rd = 1'b1; addr_in = 32'hC;
    @(negedge clk); #1;
    check_val("mid_busy_req", bus.mem_req, 32'h1);
    #1 rst = 1'b0;
    #1;
    check_val("async_rst_req", bus.mem_req, 32'h0);
    check_val("async_rst_stall", stall, 32'h0);
    check_val("async_rst_data", data_MM, 32'h0);
    rd = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rd = 1'b1; addr_in = 32'h8;
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D; #1;
    check_val("post_rst_addr", bus.mem_addr, 32'h002);
    check_val("post_rst_req", bus.mem_req, 32'h1);
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    check_val("post_rst_data", data_MM, 32'h0BAD_F00D);
    check_val("post_rst_stall", stall, 32'h0);
    check_val("post_rst_err", {err, err_code}, 32'h0);
    @(negedge clk); rd = 1'b0; #1;
    check_val("post_rst_idle", {stall, bus.mem_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
